// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the pooling sequencer state encoding.
package cnn_pkg;
  localparam int FM_COLS   = 26;
  localparam int FM_ROWS   = 26;
  localparam int POOL_COLS = FM_COLS / 2;
  localparam int POOL_ROWS = FM_ROWS / 2;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LAST,
    ST_OUT,
    ST_DONE
  } pool_state_t;
endpackage

// File: rtl/conv2_pool_ctrl_if.sv
// Result-memory read port plus pooled-output valid/ready stream.
interface conv2_pool_ctrl_if #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int OADDR_W = 8
);
  logic               mem_ren;
  logic [ADDR_W-1:0]  mem_radd;
  logic [DATA_W-1:0]  mem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [OADDR_W-1:0] out_idx;

  modport master (
    output mem_ren, mem_radd, out_valid, out_data, out_idx,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_ren, mem_radd, out_valid, out_data, out_idx,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/conv2_pool_ctrl_addr_gen.sv
// Window/sub-step counters for 2x2 pooling and the matching memory read address.
module pool_addr_gen #(
  parameter int N_C     = 26,
  parameter int N_R     = 26,
  parameter int ADDR_W  = 10,
  parameter int OADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               step_k,
  input  logic               adv_win,
  output logic [1:0]         k,
  output logic               last_win,
  output logic [ADDR_W-1:0]  radd,
  output logic [OADDR_W-1:0] win_idx
);
  localparam int HALF_C = N_C / 2;
  localparam int HALF_R = N_R / 2;
  localparam int MAX_H  = (HALF_C > HALF_R) ? HALF_C : HALF_R;
  localparam int CNT_W  = $clog2(MAX_H + 1);
  localparam int AW     = ADDR_W + 1;

  logic [CNT_W-1:0] r, c;
  logic [AW-1:0]    row_a, col_a, addr_full;

  // r also wraps after the final window so the next pass starts at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      c <= '0;
      k <= '0;
    end else if (clear) begin
      r <= '0;
      c <= '0;
      k <= '0;
    end else begin
      if (step_k) k <= k + 2'd1;
      if (adv_win) begin
        if (c == CNT_W'(HALF_C - 1)) begin
          c <= '0;
          r <= (r == CNT_W'(HALF_R - 1)) ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

  always_comb begin
    row_a     = AW'({r, k[1]});
    col_a     = AW'({c, k[0]});
    addr_full = row_a * AW'(N_C) + col_a;
  end

  assign radd     = ADDR_W'(addr_full);
  assign last_win = (r == CNT_W'(HALF_R - 1)) && (c == CNT_W'(HALF_C - 1));
  assign win_idx  = OADDR_W'(r) * OADDR_W'(HALF_C) + OADDR_W'(c);
endmodule

// File: rtl/conv2_pool_ctrl.sv
// 2x2 max-pool read sequencer for the conv-2 result memory.
// Optional fused ReLU on the output when CONV2_POOL_RELU_EN is defined.
module conv2_pool_ctrl #(
  parameter int N_C     = cnn_pkg::FM_COLS,
  parameter int N_R     = cnn_pkg::FM_ROWS,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = cnn_pkg::DATA_W,
  parameter int OADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  conv2_pool_ctrl_if.master  bus
);
  import cnn_pkg::*;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic signed [DATA_W-1:0] relu_clamp(input logic signed [DATA_W-1:0] v);
`ifdef CONV2_POOL_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  pool_state_t               state;
  logic [1:0]                k;
  logic                      last_win;
  logic [OADDR_W-1:0]        win_idx;
  logic signed [DATA_W-1:0]  acc;
  logic signed [DATA_W-1:0]  rdata_s;
  logic                      clear, step_k, adv_win;

  assign rdata_s = $signed(bus.mem_rdata);
  assign clear   = (state == ST_IDLE) && start;
  assign step_k  = (state == ST_RD);
  assign adv_win = (state == ST_OUT) && bus.out_ready;

  pool_addr_gen #(
    .N_C     (N_C),
    .N_R     (N_R),
    .ADDR_W  (ADDR_W),
    .OADDR_W (OADDR_W)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .step_k   (step_k),
    .adv_win  (adv_win),
    .k        (k),
    .last_win (last_win),
    .radd     (bus.mem_radd),
    .win_idx  (win_idx)
  );

  // Read data lags mem_ren by one cycle: sample k arrives while k+1 is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_ren   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      acc           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= ST_RD;
            busy        <= 1'b1;
            bus.mem_ren <= 1'b1;
          end
        end
        ST_RD: begin
          if (k == 2'd1)      acc <= rdata_s;
          else if (k != 2'd0) acc <= smax(acc, rdata_s);
          if (k == 2'd3) begin
            state       <= ST_LAST;
            bus.mem_ren <= 1'b0;
          end
        end
        ST_LAST: begin
          bus.out_data  <= relu_clamp(smax(acc, rdata_s));
          bus.out_idx   <= win_idx;
          bus.out_valid <= 1'b1;
          state         <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (last_win) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state       <= ST_RD;
              bus.mem_ren <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2_pool_ctrl.sv
// Scoreboard bench for conv2_pool_ctrl against a window-maximum reference model.
module tb_conv2_pool_ctrl;
  localparam int NC    = 26;
  localparam int NR    = 26;
  localparam int HC    = NC / 2;
  localparam int HR    = NR / 2;
  localparam int NWIN  = HC * HR;
  localparam int MEMSZ = NC * NR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  conv2_pool_ctrl_if #(.ADDR_W(10), .DATA_W(8), .OADDR_W(8)) bus ();

  conv2_pool_ctrl #(.N_C(NC), .N_R(NR), .ADDR_W(10), .DATA_W(8), .OADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]        mem [MEMSZ];
  logic signed [7:0] exp_data_q [$];
  int                exp_idx_q  [$];
  int                exp_addr_q [$];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, n_done = 0, n_out = 0;
  int start_cyc = 0, done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_radd];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [7:0] win_max(input int r, input int c);
    logic signed [7:0] m;
    m = $signed(mem[(2*r)*NC + 2*c]);
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if ($signed(mem[(2*r+dr)*NC + 2*c+dc]) > m) m = $signed(mem[(2*r+dr)*NC + 2*c+dc]);
`ifdef CONV2_POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  task automatic load_expect();
    for (int r = 0; r < HR; r++)
      for (int c = 0; c < HC; c++) begin
        exp_data_q.push_back(win_max(r, c));
        exp_idx_q.push_back(r*HC + c);
        for (int kk = 0; kk < 4; kk++)
          exp_addr_q.push_back((2*r + kk/2)*NC + 2*c + kk%2);
      end
  endtask

  // Monitor: outputs, read addresses and done pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_data_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL out_unexpected: got idx %0d, expected no output", bus.out_idx);
        end else begin
          chk("out_data", $signed(bus.out_data), exp_data_q.pop_front());
          chk("out_idx", bus.out_idx, exp_idx_q.pop_front());
        end
      end
      if (bus.mem_ren) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rd_unexpected: got addr %0d, expected no read", bus.mem_radd);
        end else begin
          chk("mem_radd", bus.mem_radd, exp_addr_q.pop_front());
        end
      end
      if (done) n_done++;
    end
  end

  task automatic start_pass();
    load_expect();
    n_out = 0;
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    chk("busy_before_start", busy, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_rise", busy, 1);
    chk("ren_first", bus.mem_ren, 1);
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
      end
    end
    bus.out_ready = 1'b1;
    chk("done_seen", ok, 1);
  endtask

  task automatic end_pass(input int nd0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("n_outputs", n_out, NWIN);
    chk("n_done", n_done, nd0 + 1);
    chk("sb_data_left", exp_data_q.size(), 0);
    chk("sb_addr_left", exp_addr_q.size(), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    bit ok, found, vld, stable, ren0;
    int nd0, h, i0;
    logic [7:0] d0;

    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_ren", bus.mem_ren, 0);
    chk("rst_mem_radd", bus.mem_radd, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Ramp contents with out_ready tied high: full latency check
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(i);
    nd0 = n_done;
    start_pass();
    wait_done(3000, 1'b0, ok);
    chk("pass_latency", done_cyc - start_cyc, NWIN*6 + 1);
    end_pass(nd0);

    // Flat -5 with a single -2 peak at address 53
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'hFB;
    mem[53] = 8'hFE;
    nd0 = n_done;
    start_pass();
    wait_done(3000, 1'b0, ok);
    end_pass(nd0);

    // Extreme values in window 0, both orderings, random backpressure
    for (int s = 0; s < 2; s++) begin
      fill_random();
      if (s == 0) begin mem[0] = 8'h80; mem[1] = 8'h7F; mem[26] = 8'h00; mem[27] = 8'hFF; end
      else        begin mem[0] = 8'h7F; mem[1] = 8'h80; mem[26] = 8'hFF; mem[27] = 8'h00; end
      nd0 = n_done;
      start_pass();
      wait_done(6000, 1'b1, ok);
      end_pass(nd0);
    end

    // Backpressure at output 5
    fill_random();
    nd0 = n_done;
    start_pass();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready && bus.out_idx == 8'd4) found = 1'b1;
    end
    chk("stall_reach_out4", found, 1);
    @(posedge clk); #1 bus.out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    chk("stall_out5_valid", found, 1);
    chk("stall_out5_idx", bus.out_idx, 5);
    d0 = bus.out_data; i0 = bus.out_idx;
    vld = 1'b1; stable = 1'b1; ren0 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1) vld = 1'b0;
      if (bus.out_data !== d0 || int'(bus.out_idx) != i0) stable = 1'b0;
      if (bus.mem_ren !== 1'b0) ren0 = 1'b0;
    end
    chk("stall_valid_held", vld, 1);
    chk("stall_data_stable", stable, 1);
    chk("stall_no_reads", ren0, 1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", bus.out_valid, 1);
    h = cyc;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    chk("out6_gap", cyc - h, 6);
    chk("out6_idx", bus.out_idx, 6);
    wait_done(3000, 1'b0, ok);
    end_pass(nd0);

    // Second start mid-pass must be ignored
    fill_random();
    nd0 = n_done;
    start_pass();
    repeat ($urandom_range(50, 500)) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("midstart_busy", busy, 1);
    wait_done(3000, 1'b0, ok);
    end_pass(nd0);
    repeat (10) @(negedge clk);
    chk("midstart_no_restart", busy, 0);

    // Asynchronous reset during output 40, then a clean restart
    fill_random();
    nd0 = n_done;
    start_pass();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == 8'd40) found = 1'b1;
    end
    chk("rst_reach_out40", found, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_data", bus.out_data, 0);
    chk("abort_out_idx", bus.out_idx, 0);
    chk("abort_mem_ren", bus.mem_ren, 0);
    chk("abort_mem_radd", bus.mem_radd, 0);
    exp_data_q.delete();
    exp_idx_q.delete();
    exp_addr_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", n_done, nd0);
    chk("abort_idle", busy, 0);
    fill_random();
    start_pass();
    wait_done(3000, 1'b0, ok);
    end_pass(nd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
